// File: rtl/sobel_rd_sched_if.sv
// ---------------------------------------------------------------------------
// sobel_rd_sched_if
// Groups the job, flow-control, write-completion and read-request signals of
// the Sobel read scheduler.
//   master : job issuer / environment (drives start, src_addr, num_lines,
//            the almost-full flags and write completions; observes requests
//            and status)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface sobel_rd_sched_if #(
   parameter int ADDR_W = 42,
   parameter int CNT_W  = 32
);
   // job control
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [CNT_W-1:0]  num_lines;
   // flow control
   logic              c0_alm_full;
   logic              c1_alm_full;
   logic              wfifo_alm_full;
   // write completions
   logic              wr_rsp_valid;
   logic [2:0]        wr_rsp_lines;
   // read requests
   logic              rd_req_valid;
   logic [ADDR_W-1:0] rd_req_addr;
   logic [15:0]       rd_req_mdata;
   // status
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rsp_cnt;
   logic [7:0]        outstanding;

   modport master (
      output start, src_addr, num_lines,
      output c0_alm_full, c1_alm_full, wfifo_alm_full,
      output wr_rsp_valid, wr_rsp_lines,
      input  rd_req_valid, rd_req_addr, rd_req_mdata,
      input  busy, done, req_cnt, rsp_cnt, outstanding
   );

   modport slave (
      input  start, src_addr, num_lines,
      input  c0_alm_full, c1_alm_full, wfifo_alm_full,
      input  wr_rsp_valid, wr_rsp_lines,
      output rd_req_valid, rd_req_addr, rd_req_mdata,
      output busy, done, req_cnt, rsp_cnt, outstanding
   );
endinterface

// File: rtl/sobel_rd_sched.sv
// ---------------------------------------------------------------------------
// sobel_rd_sched
// Issues one cache-line read per cycle for a job of num_lines lines starting
// at src_addr, limited by MAX_OUTSTANDING read credits and stalled while any
// almost-full flag is high. Write completions return credits. The job ends
// with a one-cycle done pulse once every line has been written back.
// Ports:
//   clk    : clock, all logic on posedge
//   Resetb : asynchronous active-low reset (release synchronized internally)
//   bus    : sobel_rd_sched_if.slave -- job control, flow control, write
//            completions, read requests and status counters
// ---------------------------------------------------------------------------
module sobel_rd_sched #(
   parameter int ADDR_W          = 42,
   parameter int CNT_W           = 32,
   parameter int MAX_OUTSTANDING = 62
) (
   input logic             clk,
   input logic             Resetb,
   sobel_rd_sched_if.slave bus
);
   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // Reset asserts immediately, releases two edges later so every flop
   // leaves reset on the same clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] src_q,     src_d;
   logic [CNT_W-1:0]  num_q,     num_d;
   logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
   logic [7:0]        out_q,     out_d;
   logic              vld_q,     vld_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [15:0]       mdata_q,   mdata_d;

   logic              issue;
   logic              rsp_take;
   logic [2:0]        rsp_lines;
   logic [2:0]        rsp_eff;
   logic [CNT_W:0]    rsp_sum;
   logic [8:0]        out_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         num_q     <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         out_q     <= '0;
         vld_q     <= 1'b0;
         addr_q    <= '0;
         mdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         num_q     <= num_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         out_q     <= out_d;
         vld_q     <= vld_d;
         addr_q    <= addr_d;
         mdata_q   <= mdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      num_d     = num_q;
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      out_d     = out_q;
      vld_d     = 1'b0;
      addr_d    = addr_q;
      mdata_d   = mdata_q;

      issue = (state_q == S_RUN) && (req_cnt_q < num_q) &&
              !bus.c0_alm_full && !bus.c1_alm_full && !bus.wfifo_alm_full &&
              (out_q < MAX_OUT);

      // Malformed completion sizes are treated as a single line.
      rsp_lines = ((bus.wr_rsp_lines == 3'd0) || (bus.wr_rsp_lines > 3'd4)) ?
                  3'd1 : bus.wr_rsp_lines;
      rsp_take  = bus.wr_rsp_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
      rsp_eff   = rsp_take ? rsp_lines : 3'd0;

      // Saturating updates: rsp_cnt never passes num_lines, outstanding never
      // goes below zero even if completions exceed issued reads.
      rsp_sum = {1'b0, rsp_cnt_q} + (CNT_W+1)'(rsp_eff);
      out_inc = {1'b0, out_q} + 9'(issue);

      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.num_lines != '0)) begin
               src_d     = bus.src_addr;
               num_d     = bus.num_lines;
               req_cnt_d = '0;
               rsp_cnt_d = '0;
               out_d     = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN, S_DRAIN: begin
            if (issue) begin
               vld_d     = 1'b1;
               addr_d    = src_q + ADDR_W'(req_cnt_q);
               mdata_d   = req_cnt_q[15:0];
               req_cnt_d = req_cnt_q + CNT_W'(1);
            end
            rsp_cnt_d = (rsp_sum > {1'b0, num_q}) ? num_q : rsp_sum[CNT_W-1:0];
            out_d     = (out_inc < 9'(rsp_eff)) ? 8'd0 : 8'(out_inc - 9'(rsp_eff));

            // Transitions look at the post-edge counts, so the state changes
            // on the same edge that the last read issues / last line lands.
            if (state_q == S_RUN) begin
               if (req_cnt_d == num_q)
                  state_d = (rsp_cnt_d == num_q) ? S_DONE : S_DRAIN;
            end else if (rsp_cnt_d == num_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rd_req_valid = vld_q;
   assign bus.rd_req_addr  = addr_q;
   assign bus.rd_req_mdata = mdata_q;
   assign bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done         = (state_q == S_DONE);
   assign bus.req_cnt      = req_cnt_q;
   assign bus.rsp_cnt      = rsp_cnt_q;
   assign bus.outstanding  = out_q;
endmodule

// File: doc/sobel_rd_sched.md
SOBEL_RD_SCHED -- requirements
Module: sobel_rd_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 42: cache-line address width.
REQ-002 SHALL have parameter CNT_W, default 32: line-count width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 62: read-credit limit.
REQ-004 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-005 SHALL have port Resetb  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1: one-cycle job-start pulse.
REQ-007 SHALL have port src_addr  in  ADDR_W: first source line address.
REQ-008 SHALL have port num_lines  in  CNT_W: job length in lines.
REQ-009 SHALL have port c0_alm_full  in  1: read-request channel almost full.
REQ-010 SHALL have port c1_alm_full  in  1: write-request channel almost full.
REQ-011 SHALL have port wfifo_alm_full  in  1: write-buffer FIFO almost full.
REQ-012 SHALL have port wr_rsp_valid  in  1: write completion present.
REQ-013 SHALL have port wr_rsp_lines  in  3: lines completed (1, 2 or 4).
REQ-014 SHALL have port rd_req_valid  out  1: read request issued this cycle.
REQ-015 SHALL have port rd_req_addr  out  ADDR_W: read request line address.
REQ-016 SHALL have port rd_req_mdata  out  16: read request tag.
REQ-017 SHALL have port busy  out  1: high in RUN or DRAIN.
REQ-018 SHALL have port done  out  1: one-cycle job-complete pulse.
REQ-019 SHALL have port req_cnt  out  CNT_W: reads issued this job.
REQ-020 SHALL have port rsp_cnt  out  CNT_W: write lines completed this job.
REQ-021 SHALL have port outstanding  out  8: issued reads minus completed lines.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE: start=1 with num_lines!=0 SHALL latch src_addr/num_lines, clear req_cnt/rsp_cnt/outstanding, and enter RUN next cycle.
REQ-024 IDLE: start=1 with num_lines==0 SHALL be ignored; state stays IDLE.
REQ-025 start SHALL be ignored outside IDLE; latched src/num_lines SHALL hold for the whole job.
REQ-026 Issue condition, evaluated in RUN: req_cnt<num_lines, all three alm_full inputs low, and outstanding<MAX_OUTSTANDING.
REQ-027 When the issue condition holds, the next edge SHALL set rd_req_valid=1, with rd_req_addr=src+req_cnt (mod 2^ADDR_W) and rd_req_mdata=req_cnt[15:0], and SHALL increment req_cnt; otherwise rd_req_valid=0.
REQ-028 At most one read SHALL be issued per cycle; rd_req_valid SHALL be a registered output; mdata SHALL wrap 0xFFFF->0x0000.
REQ-029 RUN SHALL enter DRAIN on the edge where req_cnt reaches num_lines.
REQ-030 In RUN and DRAIN, wr_rsp_valid SHALL add wr_rsp_lines to rsp_cnt and subtract it from outstanding; wr_rsp_lines of 0 or >4 SHALL count as 1.
REQ-031 A simultaneous issue and response SHALL apply both: outstanding += 1 - wr_rsp_lines.
REQ-032 outstanding SHALL saturate at 0 on underflow; rsp_cnt SHALL saturate at num_lines.
REQ-033 wr_rsp_valid in IDLE or DONE SHALL be ignored.
REQ-034 DRAIN SHALL enter DONE when rsp_cnt==num_lines; RUN SHALL go directly to DONE if both counts reach num_lines on the same edge.
REQ-035 DONE SHALL last one cycle with done=1, then return to IDLE; req_cnt/rsp_cnt SHALL hold until the next accepted start.
REQ-036 Latency: start accepted at edge T -> RUN at T+1 -> first rd_req_valid at T+2 (if unstalled).

Reset
REQ-037 Resetb=0 SHALL immediately, without clk, force IDLE and set rd_req_valid=0, rd_req_addr=0, rd_req_mdata=0, busy=0, done=0, req_cnt=0, rsp_cnt=0, outstanding=0.
REQ-038 Reset mid-job SHALL abandon the job; after release, no request SHALL issue until a new start.
REQ-039 Reset release SHALL be synchronized internally; the first active edge after release SHALL see IDLE.

Verification
REQ-040 Basic job: src=0x1000, num_lines=4, immediate responses -> addresses 0x1000-0x1003 on 4 consecutive cycles, mdata 0-3; done pulses once; rsp_cnt=4.
REQ-041 Credit limit: num_lines=100, no responses -> exactly 62 requests, then stall; outstanding=62; one 1-line response -> exactly one more request.
REQ-042 Backpressure: raise c0_alm_full, c1_alm_full, wfifo_alm_full in turn mid-job -> rd_req_valid=0 for each stalled cycle; no address skipped or repeated.
REQ-043 Mixed completions: num_lines=8, responses of 4+2+1+1 lines -> DONE after the last; a simultaneous issue and 2-line response -> outstanding decrements by 1.
REQ-044 Wrap: num_lines=0x10002 -> mdata wraps 0xFFFF->0x0000; the final address is src+0x10001.
REQ-045 Misuse/reset: start with num_lines=0 -> busy stays 0; start while busy -> ignored; Resetb low mid-DRAIN -> all outputs zero at once, and no done pulse.
